riscv_run_controller: RTL and testbench

- Synthesizable run-control and completion monitor for the RISCVunicycle core. It replaces the fixed-delay reset and `finish_flag` watch with a parametrised unit.
- Sequences the core reset and counts cycles and retired instructions.
- Detects end-of-program three ways: explicit finish flag, PC self-loop (halt idiom), or watchdog timeout.
- Sits between the testbench/top level and the core. It drives the core's active-high reset and reports a latched result.

---
 rtl/riscv_run_pkg.sv | 33 +++
 rtl/sat_counter.sv | 29 ++
 rtl/riscv_run_controller.sv | 170 +++++++++++++++++
 tb/tb_riscv_run_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_run_pkg.sv
// riscv_run_pkg
// Shared types and defaults for the RISCVunicycle run controller.
//   run_state_t  : controller FSM states
//   end_cause_t  : encoding of the reason a run ended (drives the 2-bit cause port)
//   DEF_*        : default parameter values used by riscv_run_controller
//   min_width()  : bits needed to hold a value, never less than one
package riscv_run_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } run_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_FINISH  = 2'b01,
    CAUSE_HALT    = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } end_cause_t;

  localparam int unsigned DEF_RST_CYCLES  = 100;
  localparam int unsigned DEF_TIMEOUT     = 100000;
  localparam int unsigned DEF_HALT_REPEAT = 8;

  // Width of a register that must hold values 0..max_val.
  function automatic int unsigned min_width(input int unsigned max_val);
    if (max_val < 2) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clock : system clock
//   rst   : asynchronous active-low reset (value -> 0)
//   clear : synchronous clear, wins over inc
//   inc   : count one this cycle
//   value : current count
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] value
);

  // Count up on inc, but never past the all-ones code.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (inc && (value != {W{1'b1}})) begin
      value <= value + 1'b1;
    end
  end

endmodule

// File: rtl/riscv_run_controller.sv
// riscv_run_controller
// Run-control and completion monitor for the RISCVunicycle core. Holds the
// core in reset for RST_CYCLES after a start pulse, then lets it run while
// counting cycles and retired instructions, and stops the run on the core's
// finish flag, a PC self-loop (halt idiom) or a watchdog timeout.
//   clock       : system clock
//   rst         : asynchronous active-low reset
//   start       : one-cycle pulse that begins a run (honoured in IDLE/DONE)
//   core_rst    : active-high reset to the core
//   finish_flag : core end-of-program level
//   retire      : one instruction retired this cycle
//   pc          : PC of the retiring instruction
//   busy        : reset hold or run in progress
//   done        : run finished, sticky until the next start
//   cause       : 00 none, 01 finish, 10 halt loop, 11 timeout
//   cycle_count : RUN cycles elapsed (saturating)
//   instr_count : instructions retired during RUN (saturating)
module riscv_run_controller
  import riscv_run_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT,
  parameter int unsigned HALT_REPEAT = DEF_HALT_REPEAT
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             start,
  output logic             core_rst,
  input  logic             finish_flag,
  input  logic             retire,
  input  logic [XLEN-1:0]  pc,
  output logic             busy,
  output logic             done,
  output logic [1:0]       cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned HOLD_W = min_width(RST_CYCLES - 1);
  localparam int unsigned REP_W  = min_width(HALT_REPEAT);
  // The watchdog compare is done at least 32 bits wide so a narrow counter
  // is never matched against a truncated TIMEOUT.
  localparam int unsigned CMP_W  = (CNT_W > 32) ? CNT_W : 32;

  localparam logic [HOLD_W-1:0] HOLD_LOAD    = HOLD_W'(RST_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LIMIT    = REP_W'(HALT_REPEAT);
  localparam logic [CMP_W-1:0]  TIMEOUT_LAST = CMP_W'(TIMEOUT - 1);

  run_state_t        state_q, state_d;
  end_cause_t        cause_q, cause_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [XLEN-1:0]   last_pc_q, last_pc_d;
  logic [REP_W-1:0]  rep_q, rep_d;
  logic              done_q, done_d;
  logic              core_rst_q, busy_q;
  logic              run_clear;
  logic              halt_hit, timeout_hit;
  logic [CMP_W-1:0]  cycle_ext;

  assign cycle_ext   = CMP_W'(cycle_count);
  assign halt_hit    = (HALT_REPEAT != 0) && (rep_q == REP_LIMIT);
  assign timeout_hit = (TIMEOUT != 0) && (cycle_ext == TIMEOUT_LAST);

  // State and result registers. core_rst and busy are computed from the
  // next state so that they change on the same edge as the state itself.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cause_q    <= CAUSE_NONE;
      hold_q     <= '0;
      last_pc_q  <= '0;
      rep_q      <= '0;
      done_q     <= 1'b0;
      core_rst_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      hold_q     <= hold_d;
      last_pc_q  <= last_pc_d;
      rep_q      <= rep_d;
      done_q     <= done_d;
      core_rst_q <= (state_d != RUN);
      busy_q     <= (state_d == RESET_HOLD) || (state_d == RUN);
    end
  end

  // Next-state logic. Termination checks use registered values only, with
  // finish taking priority over halt, and halt over timeout. A zero repeat
  // count means no instruction has retired yet in this run, so the first
  // retire always loads last_pc.
  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    hold_d    = hold_q;
    last_pc_d = last_pc_q;
    rep_d     = rep_q;
    done_d    = done_q;
    run_clear = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RESET_HOLD;
          hold_d    = HOLD_LOAD;
          done_d    = 1'b0;
          cause_d   = CAUSE_NONE;
          last_pc_d = '0;
          rep_d     = '0;
          run_clear = 1'b1;
        end
      end
      RESET_HOLD: begin
        if (hold_q == '0) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      RUN: begin
        if (retire) begin
          if ((rep_q != '0) && (pc == last_pc_q)) begin
            if (rep_q != {REP_W{1'b1}}) rep_d = rep_q + 1'b1;
          end else begin
            rep_d     = REP_W'(1);
            last_pc_d = pc;
          end
        end
        if (finish_flag) begin
          state_d = DONE;
          done_d  = 1'b1;
          cause_d = CAUSE_FINISH;
        end else if (halt_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
          cause_d = CAUSE_HALT;
        end else if (timeout_hit) begin
          state_d = DONE;
          done_d  = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clock (clock),
    .rst   (rst),
    .clear (run_clear),
    .inc   (state_q == RUN),
    .value (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clock (clock),
    .rst   (rst),
    .clear (run_clear),
    .inc   ((state_q == RUN) && retire),
    .value (instr_count)
  );

  assign core_rst = core_rst_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign cause    = cause_q;

endmodule

// File: tb/tb_riscv_run_controller.sv
// tb_riscv_run_controller
// Directed bench for riscv_run_controller. The main instance uses a short
// reset hold (4), watchdog of 50 and halt repeat of 8; a second instance
// uses 4-bit counters with watchdog and halt detection disabled.
module tb_riscv_run_controller;

  logic        clock;
  logic        rst;

  logic        start, finish_flag, retire;
  logic [31:0] pc;
  logic        core_rst, busy, done;
  logic [1:0]  cause;
  logic [31:0] cycle_count, instr_count;

  logic        s_start, s_finish, s_retire;
  logic [31:0] s_pc;
  logic        s_core_rst, s_busy, s_done;
  logic [1:0]  s_cause;
  logic [3:0]  s_cycle_count, s_instr_count;

  int check_count = 0;
  int error_count = 0;

  riscv_run_controller #(
    .XLEN(32), .CNT_W(32), .RST_CYCLES(4), .TIMEOUT(50), .HALT_REPEAT(8)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .start       (start),
    .core_rst    (core_rst),
    .finish_flag (finish_flag),
    .retire      (retire),
    .pc          (pc),
    .busy        (busy),
    .done        (done),
    .cause       (cause),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  riscv_run_controller #(
    .XLEN(32), .CNT_W(4), .RST_CYCLES(2), .TIMEOUT(0), .HALT_REPEAT(0)
  ) dut_small (
    .clock       (clock),
    .rst         (rst),
    .start       (s_start),
    .core_rst    (s_core_rst),
    .finish_flag (s_finish),
    .retire      (s_retire),
    .pc          (s_pc),
    .busy        (s_busy),
    .done        (s_done),
    .cause       (s_cause),
    .cycle_count (s_cycle_count),
    .instr_count (s_instr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) else begin
      error_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic st, input logic fin, input logic ret,
                               input logic [31:0] p);
    start       = st;
    finish_flag = fin;
    retire      = ret;
    pc          = p;
  endtask

  // Pulse start on the main instance and walk through the 4-cycle reset
  // hold; returns at the negedge just after the core is released.
  task automatic startRun();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("hold_core_rst_first", core_rst, 1);
    checkOutput("hold_busy", busy, 1);
    checkOutput("start_clears_done", done, 0);
    checkOutput("start_clears_cause", cause, 0);
    checkOutput("start_clears_cycles", cycle_count, 0);
    checkOutput("start_clears_instrs", instr_count, 0);
    repeat (3) begin
      @(negedge clock);
      checkOutput("hold_core_rst", core_rst, 1);
    end
    @(negedge clock);
    checkOutput("run_core_rst", core_rst, 0);
    checkOutput("run_busy", busy, 1);
    checkOutput("run_cycles_start", cycle_count, 0);
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 32'h0);
    s_start = 0; s_finish = 0; s_retire = 0; s_pc = 32'h0;
    #1 rst = 1'b0;
    #1;
    $display("[TB] reset state");
    checkOutput("rst_core_rst", core_rst, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_cause", cause, 0);
    checkOutput("rst_cycles", cycle_count, 0);
    checkOutput("rst_instrs", instr_count, 0);
    checkOutput("rst_small_core_rst", s_core_rst, 1);
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    checkOutput("idle_core_rst", core_rst, 1);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] finish_flag after 10 distinct retires");
    startRun();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 0, 1, 32'h100 + 32'(4 * i));
      @(negedge clock);
    end
    applyStimulus(0, 1, 0, 32'h0);
    @(negedge clock);
    checkOutput("fin_done", done, 1);
    checkOutput("fin_cause", cause, 1);
    checkOutput("fin_instrs", instr_count, 10);
    checkOutput("fin_cycles", cycle_count, 11);
    checkOutput("fin_core_rst", core_rst, 1);
    checkOutput("fin_busy", busy, 0);
    applyStimulus(0, 0, 1, 32'h200);
    repeat (20) @(negedge clock);
    retire = 1'b0;
    checkOutput("fin_hold_cycles", cycle_count, 11);
    checkOutput("fin_hold_instrs", instr_count, 10);
    checkOutput("fin_hold_done", done, 1);
    checkOutput("fin_hold_cause", cause, 1);

    $display("[TB] halt loop at 0x40");
    startRun();
    repeat (8) begin
      applyStimulus(0, 0, 1, 32'h40);
      @(negedge clock);
    end
    checkOutput("halt_not_yet", done, 0);
    applyStimulus(0, 0, 0, 32'h0);
    @(negedge clock);
    checkOutput("halt_done", done, 1);
    checkOutput("halt_cause", cause, 2);
    checkOutput("halt_instrs", instr_count, 8);
    checkOutput("halt_cycles", cycle_count, 9);

    $display("[TB] halt loop broken after 7 repeats");
    startRun();
    repeat (7) begin
      applyStimulus(0, 0, 1, 32'h40);
      @(negedge clock);
    end
    checkOutput("brk_no_halt_7", done, 0);
    applyStimulus(0, 0, 1, 32'h44);
    @(negedge clock);
    repeat (7) begin
      applyStimulus(0, 0, 1, 32'h40);
      @(negedge clock);
    end
    checkOutput("brk_no_halt_15", done, 0);
    applyStimulus(0, 0, 1, 32'h40);
    @(negedge clock);
    checkOutput("brk_no_halt_16", done, 0);
    applyStimulus(0, 0, 0, 32'h0);
    @(negedge clock);
    checkOutput("brk_done", done, 1);
    checkOutput("brk_cause", cause, 2);
    checkOutput("brk_instrs", instr_count, 16);
    checkOutput("brk_cycles", cycle_count, 17);

    $display("[TB] finish_flag already high at run entry");
    applyStimulus(0, 1, 0, 32'h0);
    startRun();
    checkOutput("entry_not_done", done, 0);
    @(negedge clock);
    checkOutput("entry_done", done, 1);
    checkOutput("entry_cause", cause, 1);
    checkOutput("entry_cycles", cycle_count, 1);
    applyStimulus(0, 0, 0, 32'h0);

    $display("[TB] watchdog, with a start pulse ignored mid-run");
    startRun();
    repeat (10) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("ign_start_cycles", cycle_count, 11);
    checkOutput("ign_start_core_rst", core_rst, 0);
    checkOutput("ign_start_busy", busy, 1);
    repeat (38) @(negedge clock);
    checkOutput("wd_cycles_49", cycle_count, 49);
    checkOutput("wd_not_done", done, 0);
    @(negedge clock);
    checkOutput("wd_done", done, 1);
    checkOutput("wd_cause", cause, 3);
    checkOutput("wd_cycles", cycle_count, 50);
    checkOutput("wd_instrs", instr_count, 0);

    $display("[TB] finish_flag and watchdog in the same cycle");
    startRun();
    repeat (49) @(negedge clock);
    applyStimulus(0, 1, 0, 32'h0);
    @(negedge clock);
    checkOutput("tie_cause", cause, 1);
    checkOutput("tie_cycles", cycle_count, 50);
    checkOutput("tie_done", done, 1);
    applyStimulus(0, 0, 0, 32'h0);

    $display("[TB] reset asserted mid-run");
    startRun();
    repeat (5) @(negedge clock);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_core_rst", core_rst, 1);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_cycles", cycle_count, 0);
    checkOutput("mid_rst_done", done, 0);
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    checkOutput("post_rst_core_rst", core_rst, 1);
    checkOutput("post_rst_busy", busy, 0);

    $display("[TB] 4-bit counters saturate");
    s_retire = 1'b1;
    s_pc     = 32'h80;
    s_start  = 1'b1;
    @(negedge clock);
    s_start = 1'b0;
    checkOutput("sm_hold_core_rst0", s_core_rst, 1);
    checkOutput("sm_hold_busy", s_busy, 1);
    @(negedge clock);
    checkOutput("sm_hold_core_rst1", s_core_rst, 1);
    @(negedge clock);
    checkOutput("sm_run_core_rst", s_core_rst, 0);
    repeat (10) @(negedge clock);
    checkOutput("sm_cycles_10", s_cycle_count, 10);
    checkOutput("sm_instrs_10", s_instr_count, 10);
    repeat (9) @(negedge clock);
    s_finish = 1'b1;
    @(negedge clock);
    s_finish = 1'b0;
    s_retire = 1'b0;
    checkOutput("sm_done", s_done, 1);
    checkOutput("sm_cause", s_cause, 1);
    checkOutput("sm_cycles_sat", s_cycle_count, 15);
    checkOutput("sm_instrs_sat", s_instr_count, 15);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
